// File: rtl/rdy_ack_pkg.sv
// Shared types and helpers for the rdy/ack streaming width converters.
package rdy_ack_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

    function automatic logic hs_fire(input logic rdy, input logic ack);
        return rdy & ack;
    endfunction

endpackage

// File: rtl/rdy_ack_serializer.sv
// Wide-to-narrow rdy/ack serializer: one wide word in, len+1 narrow beats out, o_last on the final beat.
// Define RDY_ACK_SER_MSB_FIRST_EN to emit the highest-index beat first instead of beat 0.
module rdy_ack_serializer
    import rdy_ack_pkg::*;
#(
    parameter int NB    = 4,
    parameter int BW_M1 = 7,
    parameter int CW_M1 = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_rdy,
    output logic                        i_ack,
    input  logic [NB*(BW_M1+1)-1:0]     i_data,
    input  logic [CW_M1:0]              i_len,
    output logic                        o_rdy,
    input  logic                        o_ack,
    output logic [BW_M1:0]              o_data,
    output logic                        o_last,
    output logic                        busy
);

    localparam int BW = BW_M1 + 1;
    localparam int DW = NB * BW;
    localparam int CW = CW_M1 + 1;

    state_t          state_q, state_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [CW_M1:0]  cnt_q, cnt_d;
    logic [CW_M1:0]  len_clamped;
    logic [DW-1:0]   load_word;
    logic            word_fire;
    logic            beat_fire;

    assign len_clamped = CW'(clamp_len(32'(i_len), NB - 1));

    assign o_rdy  = (state_q == SEND);
    assign busy   = (state_q == SEND);
    assign o_last = (state_q == SEND) && (cnt_q == '0);

`ifdef RDY_ACK_SER_MSB_FIRST_EN
    // Pre-align so beat len sits in the top slot; unused high beats fall off the end.
    assign load_word = i_data << ((NB - 1 - 32'(len_clamped)) * BW);
    assign o_data    = shift_q[DW-1 -: BW];
`else
    assign load_word = i_data;
    assign o_data    = shift_q[BW-1:0];
`endif

    assign beat_fire = hs_fire(o_rdy, o_ack);
    assign i_ack     = !rst && ((state_q == IDLE) || (beat_fire && o_last));
    assign word_fire = hs_fire(i_rdy, i_ack);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (beat_fire && !o_last) begin
`ifdef RDY_ACK_SER_MSB_FIRST_EN
            shift_d = shift_q << BW;
`else
            shift_d = shift_q >> BW;
`endif
            cnt_d = cnt_q - 1'b1;
        end else if (beat_fire) begin
            state_d = IDLE;
        end
        // A new word may land in the same cycle the last beat leaves, giving no bubble.
        if (word_fire) begin
            state_d = SEND;
            shift_d = load_word;
            cnt_d   = len_clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
